// File: rtl/store_stage.sv
// Output end of the SHAKE pipeline: serialises squeezed rate blocks into w-bit
// words, counts down the requested length and zero-fills the final word's tail.
module store_stage #(
  parameter int unsigned w        = 64,
  parameter int unsigned RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [31:0]         output_size,
  input  logic [1:0]          operation_mode,
  input  logic                block_valid_i,
  input  logic [RATE_MAX-1:0] block_in,
  output logic                block_ready_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [w-1:0]        data_out,
  output logic                last_o,
  output logic                done_o
);

  localparam int unsigned WPB128 = RATE_MAX / w;
  localparam int unsigned WPB256 = 1088 / w;
  localparam int unsigned IDX_W  = $clog2(WPB128 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLOCK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [RATE_MAX-1:0] r_block_buf;
  logic [31:0]         r_remaining;
  logic [IDX_W-1:0]    r_word_idx;
  logic [IDX_W-1:0]    r_wpb;
  logic                r_block_ready;
  logic                r_valid;
  logic                r_last;
  logic                r_done;
  logic [w-1:0]        r_data;

  logic [31:0]         w_take;
  logic [31:0]         w_rem_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic                w_end_of_block;
  logic [w-1:0]        w_next_word;

  // Keep only the low min(w, rem) bits of a word.
  function automatic logic [w-1:0] tail_mask(input logic [w-1:0] word,
                                             input logic [31:0]  rem);
    logic [w-1:0] m;
    if (rem >= 32'(w)) m = '1;
    else               m = ~({w{1'b1}} << rem);
    return word & m;
  endfunction

  always_comb begin
    w_take         = (r_remaining >= 32'(w)) ? 32'(w) : r_remaining;
    w_rem_next     = r_remaining - w_take;
    w_idx_next     = r_word_idx + IDX_W'(1);
    w_end_of_block = (r_word_idx == r_wpb - IDX_W'(1));
    w_next_word    = r_block_buf[w_idx_next*w +: w];
  end

  // Outputs are registered: the next word is prepared on the same edge that
  // retires the current one, so valid_o never sees ready_i combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_block_buf   <= '0;
      r_remaining   <= '0;
      r_word_idx    <= '0;
      r_wpb         <= '0;
      r_block_ready <= 1'b0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_done        <= 1'b0;
      r_data        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_remaining <= output_size;
            r_wpb       <= (operation_mode == 2'b00) ? IDX_W'(WPB128) : IDX_W'(WPB256);
            if (output_size == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= S_WAIT_BLOCK;
              r_block_ready <= 1'b1;
            end
          end
        end

        S_WAIT_BLOCK: begin
          if (block_valid_i) begin
            r_block_buf   <= block_in;
            r_word_idx    <= '0;
            r_state       <= S_EMIT;
            r_block_ready <= 1'b0;
            r_valid       <= 1'b1;
            r_data        <= tail_mask(block_in[w-1:0], r_remaining);
            r_last        <= (r_remaining <= 32'(w));
          end
        end

        S_EMIT: begin
          if (ready_i) begin
            r_remaining <= w_rem_next;
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              r_done  <= 1'b1;
            end else if (w_end_of_block) begin
              r_state       <= S_WAIT_BLOCK;
              r_valid       <= 1'b0;
              r_last        <= 1'b0;
              r_data        <= '0;
              r_block_ready <= 1'b1;
            end else begin
              r_word_idx <= w_idx_next;
              r_data     <= tail_mask(w_next_word, w_rem_next);
              r_last     <= (w_rem_next <= 32'(w));
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign block_ready_o = r_block_ready;
  assign valid_o       = r_valid;
  assign last_o        = r_last;
  assign done_o        = r_done;
  assign data_out      = r_data;

endmodule

// File: tb/tb_store_stage.sv
// Self-checking bench for store_stage: random blocks and handshakes compared
// against a word-list model derived from output length and block contents.
module tb_store_stage;

  localparam int unsigned W        = 64;
  localparam int unsigned RATE_MAX = 1344;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i;
  logic [31:0]         output_size;
  logic [1:0]          operation_mode;
  logic                block_valid_i;
  logic [RATE_MAX-1:0] block_in;
  logic                block_ready_o;
  logic                valid_o;
  logic                ready_i;
  logic [W-1:0]        data_out;
  logic                last_o;
  logic                done_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  store_stage #(.w(W), .RATE_MAX(RATE_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .output_size    (output_size),
    .operation_mode (operation_mode),
    .block_valid_i  (block_valid_i),
    .block_in       (block_in),
    .block_ready_o  (block_ready_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_out       (data_out),
    .last_o         (last_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'(0));
    chk({tag, "_bready"}, 64'(block_ready_o), 64'(0));
    chk({tag, "_last"}, 64'(last_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_data"}, data_out, 64'(0));
  endtask

  // rmode: 0 = ready always 1, 1 = random ready, 2 = five-cycle stall on word 1.
  // abort_at >= 0 asserts rst while word abort_at is being presented.
  task automatic run_txn(input int unsigned size, input logic [1:0] mode,
                         input int rmode, input bit toggle, input int abort_at);
    logic [RATE_MAX-1:0] blkq[$];
    logic [RATE_MAX-1:0] tmp;
    logic [63:0]         ew;
    longint              rem;
    int unsigned         wpb, nwords, nblocks, j, b, st;
    bit                  exp_v, exp_br, fin, wh, bh;

    wpb     = (mode == 2'b00) ? 21 : 17;
    nwords  = (size + 63) / 64;
    nblocks = (nwords + wpb - 1) / wpb;
    for (int n = 0; n < int'(nblocks); n++) begin
      for (int i = 0; i < RATE_MAX / 32; i++) tmp[i*32 +: 32] = $urandom;
      blkq.push_back(tmp);
    end

    start_i        = 1'b1;
    output_size    = size;
    operation_mode = mode;
    @(negedge clk);
    start_i        = 1'b0;
    output_size    = $urandom;
    operation_mode = 2'($urandom);

    if (size == 0) begin
      chk("zero_done", 64'(done_o), 64'(1));
      chk("zero_valid", 64'(valid_o), 64'(0));
      chk("zero_bready", 64'(block_ready_o), 64'(0));
      @(negedge clk);
      chk("zero_done_width", 64'(done_o), 64'(0));
      chk("zero_bready2", 64'(block_ready_o), 64'(0));
      return;
    end

    j = 0; b = 0; st = 0; exp_v = 1'b0; exp_br = 1'b1; fin = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (exp_v)  chk("valid_expected", 64'(valid_o), 64'(1));
      if (exp_br) chk("bready_expected", 64'(block_ready_o), 64'(1));
      if (fin) begin
        chk("done_pulse", 64'(done_o), 64'(1));
        chk("done_valid", 64'(valid_o), 64'(0));
        chk("blocks_used", 64'(b), 64'(nblocks));
        @(negedge clk);
        chk("done_width", 64'(done_o), 64'(0));
        return;
      end
      chk("no_early_done", 64'(done_o), 64'(0));
      if (block_ready_o && b >= nblocks) chk("extra_block", 64'(block_ready_o), 64'(0));

      if (valid_o) begin
        if (abort_at >= 0 && j == unsigned'(abort_at)) begin
          rst = 1'b1; ready_i = 1'b0; block_valid_i = 1'b0;
          @(negedge clk);
          chk_idle_outputs("reset_mid");
          rst = 1'b0;
          repeat (4) begin
            @(negedge clk);
            chk_idle_outputs("post_reset");
          end
          return;
        end
        tmp = blkq[j / wpb];
        ew  = tmp[(j % wpb)*64 +: 64];
        rem = longint'(size) - longint'(j) * 64;
        if (rem < 64) ew = ew & ~({64{1'b1}} << rem);
        chk("word_data", data_out, ew);
        chk("word_last", 64'(last_o), 64'(j == nwords - 1));
        chk("bready_excl", 64'(block_ready_o), 64'(0));
      end

      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom);
        default: begin
          ready_i = !(j == 1 && st < 5);
          if (valid_o && !ready_i) st++;
        end
      endcase

      if (block_ready_o && b < nblocks) begin
        block_valid_i = toggle ? 1'($urandom) : 1'b1;
        block_in      = blkq[b];
      end else begin
        block_valid_i = toggle ? 1'($urandom) : 1'b0;
        for (int i = 0; i < RATE_MAX / 32; i++) block_in[i*32 +: 32] = $urandom;
      end

      wh     = valid_o && ready_i;
      bh     = block_ready_o && block_valid_i;
      exp_v  = bh || (valid_o && !ready_i) ||
               (wh && j + 1 < nwords && (j + 1) % wpb != 0);
      exp_br = (block_ready_o && !block_valid_i) ||
               (wh && j + 1 < nwords && (j + 1) % wpb == 0);
      fin    = wh && (j + 1 == nwords);
      if (bh) b++;
      if (wh) j++;
      @(negedge clk);
    end
    chk("timeout_words", 64'(j), 64'(nwords));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; output_size = '0; operation_mode = '0;
    block_valid_i = 1'b0; block_in = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_txn(256,  2'b00, 0, 1'b0, -1);
    run_txn(100,  2'b01, 0, 1'b0, -1);
    run_txn(1152, 2'b01, 0, 1'b0, -1);
    run_txn(700,  2'b00, 2, 1'b1, -1);
    run_txn(0,    2'b00, 0, 1'b0, -1);
    run_txn(256,  2'b00, 0, 1'b0, 2);
    run_txn(256,  2'b00, 0, 1'b0, -1);
    run_txn(1344, 2'b00, 0, 1'b0, -1);
    run_txn(1,    2'b11, 1, 1'b1, -1);
    for (int t = 0; t < 6; t++)
      run_txn($urandom_range(1, 3000), 2'($urandom), 1, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_stage.md
# store_stage

Output end of the SHAKE pipeline. Accepts squeezed rate blocks from the permutation/squeeze stage and serialises them into `w`-bit words on an external valid/ready stream. It counts down the requested output length and zero-fills the unused tail of the final word. It pulses `done_o` when the digest is fully delivered and signals the squeeze stage, one block at a time, when another rate block is needed.

## Interface
- `w`, 64 (from `keccak_pkg`): external word width in bits; must divide 1088.
- `RATE_MAX`, 1344: width of `block_in`, which is the SHAKE128 rate.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start_i` input 1: pulse that latches `output_size` and `operation_mode`. Honoured only in IDLE.
- `output_size` input 32: requested output length in bits.
- `operation_mode` input 2:
  - 2'b00: SHAKE128, 21 words/block at w=64.
  - 2'b01 or 2'b1x: SHAKE256, 17 words/block at w=64.
- `block_valid_i` input 1: squeeze stage presents a rate block.
- `block_in` input RATE_MAX: rate block, word k = `block_in[k*w +: w]`. SHAKE256 uses only the low 1088 bits.
- `block_ready_o` output 1: store stage will capture `block_in` this cycle.
- `valid_o` output 1: `data_out` holds a valid output word.
- `ready_i` input 1: consumer accepts `data_out`.
- `data_out` output w: current output word.
- `last_o` output 1: the current word is the final word of the digest.
- `done_o` output 1: one-cycle pulse after the final word is accepted, or after a zero-length request.

## Operation
- Registers:
  - `block_buf` (RATE_MAX).
  - `remaining` (32, bits still to emit).
  - `word_idx` (5 bits).
  - `words_per_block` (latched: 21 or 17 at w=64; 1344/w or 1088/w in general).
- IDLE:
  - All handshake outputs are 0.
  - `start_i` latches the mode and sets `remaining` = `output_size`.
  - If `output_size` == 0, go to DONE; otherwise go to WAIT_BLOCK.
- WAIT_BLOCK:
  - `block_ready_o` = 1.
  - When `block_valid_i` = 1, capture `block_in` into `block_buf`, clear `word_idx`, and go to EMIT.
- EMIT:
  - `valid_o` = 1.
  - `data_out` = `block_buf[word_idx*w +: w]`, AND-masked so that only the low `min(w, remaining)` bits are kept and higher bits are 0.
  - `last_o` = (`remaining` <= w).
  - On `valid_o` & `ready_i`:
    - `remaining` -= min(w, `remaining`), saturating at 0.
    - If `last_o` is set, go to DONE.
    - Else if `word_idx` == `words_per_block` - 1, go to WAIT_BLOCK.
    - Else increment `word_idx` and stay in EMIT.
- DONE: `done_o` = 1 for exactly one cycle, then return to IDLE.
- `start_i` is ignored outside IDLE. `block_valid_i` is ignored outside WAIT_BLOCK; no block is consumed.
- `operation_mode` and `output_size` are sampled only on an accepted `start_i`. Later changes to them have no effect mid-operation.
- `data_out`, `valid_o` and `last_o` are held stable while `valid_o` & !`ready_i`.
- Reset:
  - Any cycle with `rst` = 1 forces IDLE, `remaining` = 0, `word_idx` = 0 and `block_buf` = 0.
  - All outputs reset to 0. This applies mid-emission too: a partially emitted digest is abandoned and no `done_o` is produced.

## Timing
- `start_i` in cycle N puts the block in WAIT_BLOCK at N+1, so `block_ready_o` is 1 in N+1.
- For a zero-length request, `done_o` is 1 in N+1.
- Block accepted in cycle M gives the first `valid_o` in M+1. The first word is therefore registered with 1-cycle latency.
- Within a block, throughput is one word per cycle while `ready_i` = 1.
- At a block boundary, the last word is accepted in cycle K and `block_ready_o` is 1 in K+1. If `block_valid_i` is 1 in K+1, the next word appears in K+2: one bubble.
- Final word accepted in cycle L gives `done_o` in L+1 and IDLE in L+2. A new `start_i` is accepted from L+2.
- `valid_o` never depends combinationally on `ready_i`. `block_ready_o` depends only on state.

## Test plan
- **SHAKE128, `output_size`=256, w=64, `ready_i` held 1:**
  - One block is consumed.
  - Words 0..3 = `block_in[63:0]` .. `block_in[255:192]` on consecutive cycles.
  - `last_o` is set only on word 3; `done_o` pulses one cycle later; `block_ready_o` is never reasserted.
- **SHAKE256, `output_size`=100:**
  - Two words are emitted.
  - Word 1 = `block_in[127:64]` with bits [63:36] forced to 0, and `last_o`=1 on it.
- **SHAKE256, `output_size`=1152 (18 words):**
  - 17 words come from block A; `block_ready_o` reasserts; 1 word comes from block B (`B[63:0]`) with `last_o`=1.
  - Exactly two blocks are handshaken.
- **Back-pressure:**
  - Drop `ready_i` for 5 cycles mid-block: `data_out`, `valid_o` and `last_o` are unchanged throughout, and no word is skipped or duplicated.
  - Toggle `block_valid_i` in EMIT: no capture occurs.
- **Zero length and reset:**
  - `output_size`=0: `done_o` pulses at N+1, with no `valid_o` and no `block_ready_o`.
  - Assert `rst` during word 2 of 4: all outputs are 0 the next cycle, there is no `done_o`, and a fresh `start_i` then works normally.
